emoji_message_composer: RTL
===========================

# emoji_message_composer

- Sits directly downstream of the emoji button debouncer.
- Turns debounced, level-type emoji button inputs into a composed message of emoji codes, held in a small buffer.
- On a debounced send request, streams the message to the transmitter over a valid/ready handshake, then empties the buffer.
- Also provides clear, length reporting and overflow signalling for the message display logic.

## Interface

Parameters:
- DEPTH, 8: message slots (maximum emojis per message), 2..15.
- CODE_W, 3: emoji code width; codes 1..4 are emojis, 0 is the "none" code.

Ports:
- FPGA_clock  input  1  system clock.
- resetn  input  1  reset, asynchronous, active-low.
- emoji_in  input  4  debounced emoji buttons, level, bit i = emoji i+1.
- send_in  input  1  debounced send button, level.
- clear_in  input  1  debounced clear button, level.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- tx_valid  output  1  tx_data holds a message element.
- tx_data  output  CODE_W  emoji code being offered.
- tx_last  output  1  the offered element is the final one of the message.
- msg_len  output  4  emojis currently buffered, 0..DEPTH.
- full  output  1  msg_len == DEPTH.
- sending  output  1  state is SEND.
- dropped  output  1  one-cycle pulse when an emoji press is discarded.

## Operation

Rising-edge detection:
- Registered previous samples of emoji_in, send_in and clear_in.
- press = in & ~prev.
- The previous-sample registers reset to all ones, so buttons held through reset release never generate a press.

Emoji encode:
- If any emoji press bit is set, code = (index of the lowest set bit) + 1.
- Other simultaneous press bits are ignored, with no dropped pulse for them.

State machine, states IDLE and SEND:
- IDLE, evaluated in this priority order each cycle:
  - clear press: msg_len ← 0.
  - else send press with msg_len > 0: rd_ptr ← 0, go to SEND.
  - else send press with msg_len == 0: ignored.
  - else emoji press with !full: slot[msg_len] ← code, msg_len ← msg_len+1.
  - else emoji press with full: dropped pulses.
  - A send or clear press in the same cycle as an emoji press discards the emoji (dropped pulses).
- SEND:
  - tx_valid = 1, tx_data = slot[rd_ptr], tx_last = (rd_ptr == msg_len-1).
  - On tx_valid & tx_ready: if tx_last, go to IDLE with msg_len ← 0; else rd_ptr ← rd_ptr+1.
  - Emoji, send and clear presses are ignored; dropped pulses for emoji presses.
  - Edge history keeps updating in SEND, so a button held across SEND→IDLE does not fire on exit.

Output rules:
- tx_data and tx_last hold stable while tx_valid & !tx_ready.
- tx_data = 0 whenever tx_valid = 0.
- Buffer contents are not cleared, only msg_len; slots at or above msg_len are don't-care.

Reset values (asynchronous, any state including mid-SEND):
- State IDLE.
- msg_len = 0, rd_ptr = 0.
- tx_valid = 0, tx_data = 0, tx_last = 0.
- sending = 0, full = 0, dropped = 0.
- Edge history all ones.
- A partially sent message is lost; the transmitter sees tx_valid fall.

## Timing

- All outputs are registered, or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Emoji press visible on emoji_in at edge n: msg_len/full update after edge n, visible in cycle n+1. Press-to-buffer latency is 1 cycle.
- Send press at edge n: sending = tx_valid = 1 from cycle n+1.
- Handshake at edge m: the next element is offered in cycle m+1.
- Zero-stall throughput: one element per cycle. An N-emoji message occupies SEND for exactly N cycles.
- After the final handshake at edge m: IDLE, msg_len = 0, tx_valid = 0 in cycle m+1. A press at edge m+1 is accepted.
- dropped is high for exactly the cycle after the offending edge.

## Structure

- Shared package emoji_pkg:
  - CODE_W.
  - Emoji codes EMOJI_NONE=0 and EMOJI_1..EMOJI_4=1..4.
  - State encoding (IDLE=0, SEND=1).
  - DEPTH default.
  - The transmitter and display blocks also decode these codes.
- Sub-module rise_detect:
  - Parameterised width; resetn presets history to ones.
  - Instantiated three times: width 4 for emoji_in, width 1 each for send_in and clear_in.
- Buffer is a flat register array indexed by msg_len (write) and rd_ptr (read); no wrap-around, since SEND always starts at slot 0.

## Test plan

- Reset with emoji_in=4'b0100 held, then release reset and keep it held: msg_len stays 0. Drop emoji_in to 0, then raise it to 4'b0100: msg_len=1, slot 0 = 3.
- Press emojis 1,2,4,3, then send with tx_ready=1: tx_data = 1,2,4,3 in four consecutive cycles, tx_last only on the 3; msg_len=0 in the next cycle.
- Buffer 2 emojis, send, hold tx_ready=0 for 5 cycles: tx_data=first code and tx_last=0 steady. Assert reset mid-SEND: tx_valid=0, msg_len=0 immediately.
- Press 10 emojis with DEPTH=8: full=1 after the 8th; dropped pulses on the 9th and 10th; msg_len stays 8. Press clear: msg_len=0, full=0.
- emoji_in goes 0→4'b1010 with send_in rising the same edge and msg_len=1: SEND entered, dropped=1, one element (the old code) sent. Send press with msg_len=0: stays IDLE.

Source files
------------

// File: rtl/emoji_pkg.sv
// rtl/emoji_pkg.sv - shared emoji codes, state encoding and message defaults
package emoji_pkg;

  localparam int CODE_W    = 3;
  localparam int DEPTH_DEF = 8;

  localparam logic [CODE_W-1:0] EMOJI_NONE = 3'd0;
  localparam logic [CODE_W-1:0] EMOJI_1    = 3'd1;
  localparam logic [CODE_W-1:0] EMOJI_2    = 3'd2;
  localparam logic [CODE_W-1:0] EMOJI_3    = 3'd3;
  localparam logic [CODE_W-1:0] EMOJI_4    = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Lowest pressed button wins when several rise together.
  function automatic logic [1:0] lowest_index(input logic [3:0] p);
    if (p[0]) return 2'd0;
    if (p[1]) return 2'd1;
    if (p[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector; history presets to ones so held buttons never fire
module rise_detect #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= '1;
    else         prev_q <= in_i;
  end

  assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/emoji_message_composer.sv
// rtl/emoji_message_composer.sv - composes emoji presses into a buffered message and streams it on send
module emoji_message_composer #(
  parameter int DEPTH  = emoji_pkg::DEPTH_DEF,
  parameter int CODE_W = emoji_pkg::CODE_W
) (
  input  logic              FPGA_clock,
  input  logic              resetn,
  input  logic [3:0]        emoji_in,
  input  logic              send_in,
  input  logic              clear_in,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [CODE_W-1:0] tx_data,
  output logic              tx_last,
  output logic [3:0]        msg_len,
  output logic              full,
  output logic              sending,
  output logic              dropped
);
  import emoji_pkg::*;

  logic [3:0] emoji_rise;
  logic       send_rise, clear_rise, emoji_any;
  logic [CODE_W-1:0] code_w;

  state_e state_q, state_d;
  logic [3:0] msg_len_q, msg_len_d, rd_ptr_q, rd_ptr_d;
  logic       dropped_q, dropped_d, wr_en, full_w, last_w;
  logic [CODE_W-1:0] slot_q [16];

  rise_detect #(.W(4)) u_rise_emoji (.clk_i(FPGA_clock), .rst_ni(resetn), .in_i(emoji_in), .rise_o(emoji_rise));
  rise_detect #(.W(1)) u_rise_send  (.clk_i(FPGA_clock), .rst_ni(resetn), .in_i(send_in),  .rise_o(send_rise));
  rise_detect #(.W(1)) u_rise_clear (.clk_i(FPGA_clock), .rst_ni(resetn), .in_i(clear_in), .rise_o(clear_rise));

  assign emoji_any = |emoji_rise;
  assign code_w    = CODE_W'(lowest_index(emoji_rise)) + CODE_W'(1);
  assign full_w    = (msg_len_q == 4'(DEPTH));
  assign last_w    = (rd_ptr_q == msg_len_q - 4'd1);

  always_ff @(posedge FPGA_clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!clear_rise && send_rise && msg_len_q != 4'd0) state_d = ST_SEND;
      ST_SEND: if (tx_ready && last_w) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sending  = (state_q == ST_SEND);
    tx_valid = sending;
    tx_data  = sending ? slot_q[rd_ptr_q] : EMOJI_NONE;
    tx_last  = sending && last_w;
    msg_len  = msg_len_q;
    full     = full_w;
    dropped  = dropped_q;
  end

  // Any emoji press that does not land in the buffer raises dropped.
  always_comb begin
    msg_len_d = msg_len_q;
    rd_ptr_d  = rd_ptr_q;
    dropped_d = 1'b0;
    wr_en     = 1'b0;
    if (state_q == ST_IDLE) begin
      if (clear_rise) begin
        msg_len_d = 4'd0;
        dropped_d = emoji_any;
      end else if (send_rise) begin
        rd_ptr_d  = 4'd0;
        dropped_d = emoji_any;
      end else if (emoji_any) begin
        if (!full_w) begin
          wr_en     = 1'b1;
          msg_len_d = msg_len_q + 4'd1;
        end else begin
          dropped_d = 1'b1;
        end
      end
    end else begin
      dropped_d = emoji_any;
      if (tx_ready) begin
        if (last_w) msg_len_d = 4'd0;
        else        rd_ptr_d  = rd_ptr_q + 4'd1;
      end
    end
  end

  always_ff @(posedge FPGA_clock or negedge resetn) begin
    if (!resetn) begin
      msg_len_q <= 4'd0;
      rd_ptr_q  <= 4'd0;
      dropped_q <= 1'b0;
    end else begin
      msg_len_q <= msg_len_d;
      rd_ptr_q  <= rd_ptr_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge FPGA_clock) begin
    if (wr_en) slot_q[msg_len_q] <= code_w;
  end

endmodule
